// File: rtl/divider_pkg.sv
// Shared types and constants for the multi-lane sequential fixed-point divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int LANE_W    = 16;
    localparam int LANE_FRAC = 12;
    localparam int QW        = LANE_W + LANE_FRAC;

    localparam logic [LANE_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [LANE_W-1:0] SAT_NEG = 16'h8000;

    function automatic int lane_slice(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/div_lane_step.sv
// One lane of the restoring divider: remainder/quotient registers, trial
// subtractor, and the final sign/saturation mapping of the quotient.
module div_lane_step
    import divider_pkg::*;
#(
    parameter int W    = LANE_W,
    parameter int FRAC = LANE_FRAC
) (
    input  logic         clk,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] q_in,
    input  logic         m_sign,
    input  logic [W:0]   m_mag,
    input  logic         dz,
    output logic [W-1:0] res,
    output logic         res_ovf
);

    localparam int QBITS = W + FRAC;

    localparam logic [W-1:0]     SAT_P   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAT_N   = {1'b1, {(W-1){1'b0}}};
    localparam logic [QBITS-1:0] POS_LIM = {{(FRAC+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [QBITS-1:0] NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(W-1){1'b0}}};

    logic [W-1:0]     rem_p0;
    logic [QBITS-1:0] dq_p0;
    logic             sign_p0;
    logic             zero_p0;

    logic signed [W:0] q_ext;
    logic [W:0]        q_mag;
    logic [W:0]        r_sh;
    logic [W:0]        diff;
    logic              ge;
    logic [QBITS-1:0]  dq_nxt;
    logic [W:0]        sat_res;

    // Returns {overflow, lane value}; magnitude is the unsigned quotient.
    function automatic logic [W:0] saturate(input logic [QBITS-1:0] mag, input logic neg);
        if (!neg)
            return (mag > POS_LIM) ? {1'b1, SAT_P} : {1'b0, W'(mag)};
        return (mag > NEG_LIM) ? {1'b1, SAT_N} : {1'b0, W'(-mag)};
    endfunction

    always_comb begin
        q_ext   = {q_in[W-1], q_in};
        q_mag   = q_in[W-1] ? $unsigned(-q_ext) : $unsigned(q_ext);
        r_sh    = {rem_p0, dq_p0[QBITS-1]};
        ge      = (r_sh >= m_mag);
        diff    = r_sh - m_mag;
        dq_nxt  = {dq_p0[QBITS-2:0], ge};
        sat_res = saturate(dq_nxt, sign_p0);
        if (dz) begin
            res     = zero_p0 ? '0 : (sign_p0 ? SAT_N : SAT_P);
            res_ovf = 1'b0;
        end else begin
            res     = sat_res[W-1:0];
            res_ovf = sat_res[W];
        end
    end

    // Stage p0: dividend bits shift out the top while quotient bits shift in below.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_p0  <= '0;
            dq_p0   <= QBITS'(q_mag) << FRAC;
            sign_p0 <= q_in[W-1] ^ m_sign;
            zero_p0 <= (q_in == '0);
        end else if (step) begin
            rem_p0 <= W'(ge ? diff : r_sh);
            dq_p0  <= dq_nxt;
        end
    end

endmodule

// File: rtl/divider_nover1_seq.sv
// N-lane signed fixed-point divider sharing one divisor; one quotient bit per
// enabled cycle with saturation and divide-by-zero flagging.
module divider_nover1_seq
    import divider_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int W       = LANE_W,
    parameter int FRAC    = LANE_FRAC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 valid_in,
    output logic                 accept_out,
    input  logic [N_LANES*W-1:0] Q,
    input  logic [W-1:0]         M,
    output logic                 ready_out,
    input  logic                 accept_in,
    output logic [N_LANES*W-1:0] quot,
    output logic                 div_zero,
    output logic [N_LANES-1:0]   ovf
);

    localparam int QBITS = W + FRAC;
    localparam int CW    = $clog2(QBITS);

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [W:0]    m_mag_p0;
    logic          dz_p0;
    logic          capture;
    logic          step;
    logic          finish;

    logic signed [W:0]    m_ext;
    logic [W:0]           m_mag;
    logic [N_LANES*W-1:0] lane_res;
    logic [N_LANES-1:0]   lane_ovf;

    always_comb begin
        m_ext = {M[W-1], M};
        m_mag = M[W-1] ? $unsigned(-m_ext) : $unsigned(m_ext);
    end

    always_comb begin
        state_nxt  = state;
        accept_out = 1'b0;
        ready_out  = 1'b0;
        capture    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                accept_out = 1'b1;
                if (enable && valid_in) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (enable) begin
                    step = 1'b1;
                    // A zero divisor needs no iterations: its result is known at capture.
                    if (dz_p0 || cnt == '0) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                ready_out = 1'b1;
                if (enable && accept_in)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            quot     <= '0;
            div_zero <= 1'b0;
            ovf      <= '0;
        end else begin
            state <= state_nxt;
            if (capture)
                cnt <= CW'(QBITS - 1);
            else if (step && !finish)
                cnt <= cnt - 1'b1;
            if (finish) begin
                quot     <= lane_res;
                ovf      <= lane_ovf;
                div_zero <= dz_p0;
            end
        end
    end

    // Stage p0: shared divisor magnitude held for the whole iteration.
    always_ff @(posedge clk) begin
        if (capture) begin
            m_mag_p0 <= m_mag;
            dz_p0    <= (M == '0);
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        localparam int BASE = lane_slice(i, W);
        div_lane_step #(
            .W    (W),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .load    (capture),
            .step    (step),
            .q_in    (Q[BASE +: W]),
            .m_sign  (M[W-1]),
            .m_mag   (m_mag_p0),
            .dz      (dz_p0),
            .res     (lane_res[BASE +: W]),
            .res_ovf (lane_ovf[i])
        );
    end

endmodule

// File: tb/tb_divider_nover1_seq.sv
// Bench for divider_nover1_seq: directed vector table, stall/backpressure/reset
// sequences, and randomized transactions against an arithmetic reference.
module tb_divider_nover1_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid_in;
    logic        accept_out;
    logic [63:0] Q;
    logic [15:0] M;
    logic        ready_out;
    logic        accept_in;
    logic [63:0] quot;
    logic        div_zero;
    logic [3:0]  ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    divider_nover1_seq #(.N_LANES(4), .W(16), .FRAC(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .valid_in   (valid_in),
        .accept_out (accept_out),
        .Q          (Q),
        .M          (M),
        .ready_out  (ready_out),
        .accept_in  (accept_in),
        .quot       (quot),
        .div_zero   (div_zero),
        .ovf        (ovf)
    );

    typedef struct {
        logic [63:0] q;
        logic [15:0] m;
        logic [63:0] eq;
        logic [3:0]  eo;
        logic        ed;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Quotient per lane = trunc(Q*2^12 / M), clamped to the 16-bit signed range.
    function automatic void ref_model(input logic [63:0] q, input logic [15:0] m,
                                      output logic [63:0] qo, output logic [3:0] ov,
                                      output logic dz);
        longint mv, qv, a, b, r;
        logic neg;
        mv = longint'($signed(m));
        dz = (mv == 0);
        qo = '0;
        ov = '0;
        for (int i = 0; i < 4; i++) begin
            qv = longint'($signed(q[16*i +: 16]));
            if (dz) begin
                r = (qv > 0) ? 32767 : ((qv < 0) ? -32768 : 0);
            end else begin
                a   = (qv < 0) ? -qv : qv;
                b   = (mv < 0) ? -mv : mv;
                r   = (a * 4096) / b;
                neg = (qv < 0) != (mv < 0);
                if (neg) r = -r;
                if (r > 32767) begin
                    r = 32767;
                    ov[i] = 1'b1;
                end else if (r < -32768) begin
                    r = -32768;
                    ov[i] = 1'b1;
                end
            end
            qo[16*i +: 16] = r[15:0];
        end
    endfunction

    task automatic run_txn(input string tag, input logic [63:0] q, input logic [15:0] m,
                           input logic [63:0] eq, input logic [3:0] eo, input logic ed,
                           input int elat, input int stall_at, input int stall_len,
                           input int hold);
        int lat;
        check({tag, " accept_out_idle"}, 64'(accept_out), 64'd1);
        Q        = q;
        M        = m;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        Q        = {$urandom, $urandom};
        M        = 16'($urandom);
        check({tag, " accept_out_busy"}, 64'(accept_out), 64'd0);
        lat = 0;
        while (!ready_out && lat < 200) begin
            if (lat == stall_at) enable = 1'b0;
            if (lat == stall_at + stall_len) enable = 1'b1;
            valid_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        valid_in = 1'b0;
        enable   = 1'b1;
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " quot"}, quot, eq);
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
        check({tag, " div_zero"}, 64'(div_zero), 64'(ed));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold_quot"}, quot, eq);
            check({tag, " hold_ready"}, 64'({ready_out, accept_out}), 64'b10);
        end
        accept_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accept_in = 1'b0;
        check({tag, " ready_cleared"}, 64'(ready_out), 64'd0);
    endtask

    initial begin
        logic [63:0] rq, eq;
        logic [15:0] rm;
        logic [3:0]  eo;
        logic        ed;

        tbl[0] = '{64'h0000_0666_0851_08A3, 16'h3333, 64'h0000_01FF_0299_02B2, 4'b0000, 1'b0, 28};
        tbl[1] = '{64'h0000_0000_B000_5000, 16'h3333, 64'h0000_0000_E700_1900, 4'b0000, 1'b0, 28};
        tbl[2] = '{64'h0000_8000_B000_5000, 16'hCCCD, 64'h0000_2800_1900_E700, 4'b0000, 1'b0, 28};
        tbl[3] = '{64'h1000_7FFF_9000_7000, 16'h0400, 64'h4000_7FFF_8000_7FFF, 4'b0111, 1'b0, 28};
        tbl[4] = '{64'h7FFF_0000_F000_1000, 16'h0000, 64'h7FFF_0000_8000_7FFF, 4'b0000, 1'b1, 1};
        tbl[5] = '{64'hF000_7FFF_8000_8000, 16'h8000, 64'h0200_F001_1000_1000, 4'b0000, 1'b0, 28};
        tbl[6] = '{64'hFFFF_0001_7FFF_8000, 16'h1000, 64'hFFFF_0001_7FFF_8000, 4'b0000, 1'b0, 28};
        tbl[7] = '{64'h0000_0001_7FFF_8000, 16'hF000, 64'h0000_FFFF_8001_7FFF, 4'b0001, 1'b0, 28};

        reset     = 1'b1;
        enable    = 1'b1;
        valid_in  = 1'b0;
        accept_in = 1'b0;
        Q         = '0;
        M         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset accept_out", 64'(accept_out), 64'd1);
        check("reset ready_out", 64'(ready_out), 64'd0);
        check("reset quot", quot, 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].q, tbl[i].m, tbl[i].eq, tbl[i].eo,
                    tbl[i].ed, tbl[i].lat, -1, 0, 0);

        // Enable dropped for 5 cycles mid-iteration, then 10 cycles of backpressure.
        run_txn("stall", tbl[0].q, tbl[0].m, tbl[0].eq, tbl[0].eo, tbl[0].ed, 33, 5, 5, 10);
        run_txn("dz_hold", tbl[4].q, tbl[4].m, tbl[4].eq, tbl[4].eo, tbl[4].ed, 1, -1, 0, 3);

        // Reset while iterating discards the transaction.
        Q        = tbl[3].q;
        M        = tbl[3].m;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_calc accept_out", 64'(accept_out), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("after_reset accept_out", 64'(accept_out), 64'd1);
        check("after_reset ready_out", 64'(ready_out), 64'd0);
        check("after_reset quot", quot, 64'd0);
        check("after_reset ovf", 64'(ovf), 64'd0);
        run_txn("post_reset", tbl[1].q, tbl[1].m, tbl[1].eq, tbl[1].eo, tbl[1].ed, 28, -1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 5))
                    0:       rq[16*l +: 16] = 16'h8000;
                    1:       rq[16*l +: 16] = 16'h7FFF;
                    2:       rq[16*l +: 16] = 16'h0000;
                    default: rq[16*l +: 16] = 16'($urandom);
                endcase
            end
            case ($urandom_range(0, 5))
                0:       rm = 16'h0000;
                1:       rm = 16'h8000;
                2:       rm = 16'($urandom_range(1, 63));
                default: rm = 16'($urandom);
            endcase
            ref_model(rq, rm, eq, eo, ed);
            run_txn($sformatf("rnd%0d", t), rq, rm, eq, eo, ed, (rm == 16'h0) ? 1 : 28,
                    -1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
